temp_sample_ctrl: RTL and testbench
===================================

// Module: temp_sample_ctrl
// PURPOSE
//  Sequencer that feeds the temperature monitor. It periodically requests a reading from the sensor
//  interface (req/ack) and latches the signed 3-digit BCD value. It computes the signed BCD delta
//  against the previous reading, then publishes value, delta and the monitor enable strobe.
//  It sits between the sensor front end and the monitor; the monitor's state codes live in constants.h.
// PARAMETERS
//  TICK_DIV     50_000_000  clk cycles between sample requests (1 s at 50 MHz); >= 4
//  ACK_TIMEOUT  255         max cycles sample_req waits for sample_ack before abort
//  EN_HOLD      16          cycles mon_en stays high per published sample; >= 1
// PORTS
//  clk            in   1   system clock, all logic on posedge
//  rst_n          in   1   synchronous reset, active low
//  run            in   1   level; 1 = periodic sampling enabled
//  clear_err      in   1   1-cycle pulse; clears sticky error flags
//  sample_ack     in   1   sensor data valid; sensor_* sampled on the cycle it is high
//  sensor_ones    in   4   BCD units digit
//  sensor_tens    in   4   BCD tens digit
//  sensor_huns    in   4   BCD hundreds digit
//  sensor_sign    in   1   1 = negative reading
//  sample_req     out  1   request to sensor; held high until ack or timeout
//  temp_value_*   out  4/4/4/1  ones/tens/huns/sign of the last accepted reading
//  temp_delta_*   out  4/4/4/1  |new-prev| as BCD ones/tens/huns, plus sign (1 = new < prev)
//  mon_en         out  1   monitor enable; high EN_HOLD cycles after each publish
//  busy           out  1   1 in any state other than WAIT_TICK
//  timeout_err    out  1   sticky: a request hit ACK_TIMEOUT
//  bad_data_err   out  1   sticky: an acked reading had a BCD digit > 9
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0, state WAIT_TICK, tick_cnt=0, have_prev=0, prev=0.
//  States: WAIT_TICK -> REQ -> CAPTURE -> DELTA -> PUBLISH -> WAIT_TICK.
//  WAIT_TICK: tick_cnt counts only while run=1 and resets to 0 when run=0. When tick_cnt reaches
//    TICK_DIV-1: tick_cnt<=0 and go to REQ. mon_en stays high here until its EN_HOLD counter expires.
//  REQ: sample_req=1 starting the cycle after entry. On sample_ack=1: latch sensor_* and go to CAPTURE
//    (sample_req low the next cycle). If wait_cnt reaches ACK_TIMEOUT with no ack: drop sample_req,
//    set timeout_err, return to WAIT_TICK; outputs unchanged.
//  CAPTURE: if any latched digit > 9, set bad_data_err and go to WAIT_TICK, discarding the reading.
//    Otherwise go to DELTA.
//  DELTA: diff = signed(new) - signed(prev), each value in -999..+999.
//    delta magnitude = min(|diff|, 999), encoded as BCD. delta_sign = (diff < 0).
//    -0 is treated as +0 (negative zero in gives delta_sign 0 when diff = 0).
//    If have_prev=0: delta = 0, delta_sign = 0. Result is registered; 1 cycle.
//  PUBLISH (1 cycle): temp_value_* <= new, temp_delta_* <= delta, prev <= new, have_prev <= 1,
//    mon_en <= 1, hold_cnt <= EN_HOLD-1. All value/delta outputs change in the same cycle.
//  mon_en: falls after exactly EN_HOLD cycles high. If EN_HOLD >= TICK_DIV, mon_en is forced low
//    for 1 cycle on entry to REQ, so every publish produces a fresh rising edge for the monitor.
//  Latency: sample_ack cycle to outputs/mon_en updated is 3 clk (CAPTURE, DELTA, PUBLISH).
//  run=0 mid-sample: the in-flight sample completes; only new ticks are inhibited.
//  Errors: clear_err clears both sticky flags. If clear_err coincides with a new error, the error wins.
//  rst_n=0 in any state: aborts immediately, sample_req drops the next edge, have_prev cleared.
// STRUCTURE
//  constants.h: add `define codes for the FSM states (3 bits). Monitor STATE_* codes are reused, not duplicated.
//  Sub-module bcd_signed_diff: combinational; inputs two sign+3-digit BCD values;
//    outputs saturated BCD magnitude + sign; instantiated once and registered in DELTA.
//  Top level holds the FSM, tick/wait/hold counters, prev register and output registers (~250 lines).
// TESTING (TICK_DIV=8, ACK_TIMEOUT=5, EN_HOLD=3)
//  1 Reset, run=1, ack +023 after 2 cycles of req -> value=023 sign 0, delta=000, mon_en high 3 cycles,
//    3 clk after ack.
//  2 Second reading +031 after +023 -> delta=008, delta_sign 0. Then -004 -> delta=035, delta_sign 1.
//  3 prev -999, new +999 -> delta saturates at 999, delta_sign 0. Equal readings +047,+047 -> delta 000.
//  4 No ack -> sample_req high exactly 5 cycles, timeout_err=1, outputs hold.
//    Then clear_err -> 0; clear_err + timeout in the same cycle -> flag stays 1.
//  5 Ack with tens=4'hA -> bad_data_err=1, no mon_en pulse, prev unchanged.
//    The next valid reading's delta uses the old prev.
//  6 rst_n=0 while in REQ -> sample_req 0 next edge, all outputs 0.
//    run=0 during DELTA -> PUBLISH still occurs, no further req.

Source files
------------

// File: rtl/temp_sample_ctrl_pkg.sv
// Shared types and helpers for the temperature sample sequencer.
package temp_sample_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_TICK = 3'd0,
      ST_REQ       = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_DELTA     = 3'd3,
      ST_PUBLISH   = 3'd4
   } state_t;

   typedef struct packed {
      logic       sign;
      logic [3:0] huns;
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_t;

   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   function automatic logic [9:0] bcd3_to_bin(input logic [3:0] huns, input logic [3:0] tens,
                                              input logic [3:0] ones);
      return 10'(huns) * 10'd100 + 10'(tens) * 10'd10 + 10'(ones);
   endfunction

   function automatic logic bcd_has_bad_digit(input bcd_t v);
      return (v.huns > BCD_DIGIT_MAX) || (v.tens > BCD_DIGIT_MAX) || (v.ones > BCD_DIGIT_MAX);
   endfunction

endpackage

// File: rtl/temp_sample_ctrl_bcd_signed_diff.sv
// Combinational signed BCD subtract a - b, magnitude saturated to 999.
module bcd_signed_diff
   import temp_sample_ctrl_pkg::*;
(
   input  logic       a_sign,
   input  logic [3:0] a_huns,
   input  logic [3:0] a_tens,
   input  logic [3:0] a_ones,
   input  logic       b_sign,
   input  logic [3:0] b_huns,
   input  logic [3:0] b_tens,
   input  logic [3:0] b_ones,
   output logic       diff_sign,
   output logic [3:0] diff_huns,
   output logic [3:0] diff_tens,
   output logic [3:0] diff_ones
);

   logic signed [11:0] a_val;
   logic signed [11:0] b_val;
   logic signed [11:0] diff;
   logic        [11:0] diff_abs;
   logic        [9:0]  mag;

   // -0 converts to 0 here, so it never produces a negative delta
   always_comb begin
      a_val = $signed({2'b00, bcd3_to_bin(a_huns, a_tens, a_ones)});
      if (a_sign) a_val = -a_val;
      b_val = $signed({2'b00, bcd3_to_bin(b_huns, b_tens, b_ones)});
      if (b_sign) b_val = -b_val;
      diff      = a_val - b_val;
      diff_abs  = diff[11] ? $unsigned(-diff) : $unsigned(diff);
      mag       = (diff_abs > 12'd999) ? 10'd999 : diff_abs[9:0];
      diff_sign = diff[11];
      diff_huns = 4'(mag / 10'd100);
      diff_tens = 4'((mag / 10'd10) % 10'd10);
      diff_ones = 4'(mag % 10'd10);
   end

endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic sensor sampler: request, capture, signed BCD delta, publish to the monitor.
//   state        | meaning
//   ST_WAIT_TICK | idle, counting towards the next sample tick while run=1
//   ST_REQ       | sample_req high, waiting for sample_ack or timeout
//   ST_CAPTURE   | validate latched BCD digits
//   ST_DELTA     | register delta against previous reading
//   ST_PUBLISH   | update outputs, prev and start mon_en hold
module temp_sample_ctrl
   import temp_sample_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter int unsigned EN_HOLD     = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       clear_err,
   input  logic       sample_ack,
   input  logic [3:0] sensor_ones,
   input  logic [3:0] sensor_tens,
   input  logic [3:0] sensor_huns,
   input  logic       sensor_sign,
   output logic       sample_req,
   output logic [3:0] temp_value_ones,
   output logic [3:0] temp_value_tens,
   output logic [3:0] temp_value_huns,
   output logic       temp_value_sign,
   output logic [3:0] temp_delta_ones,
   output logic [3:0] temp_delta_tens,
   output logic [3:0] temp_delta_huns,
   output logic       temp_delta_sign,
   output logic       mon_en,
   output logic       busy,
   output logic       timeout_err,
   output logic       bad_data_err
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int WW = $clog2(ACK_TIMEOUT + 1);
   localparam int HW = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(EN_HOLD - 1);

   state_t        state, state_next;
   logic [TW-1:0] tick_cnt;
   logic [WW-1:0] wait_cnt;
   logic [HW-1:0] hold_cnt;
   bcd_t          new_r, prev_r, delta_r, diff_bcd, value_o, delta_o;
   logic          have_prev;
   logic          tick_hit, ack_take, timeout_hit, bad_digit;

   bcd_signed_diff u_diff (
      .a_sign    (new_r.sign),
      .a_huns    (new_r.huns),
      .a_tens    (new_r.tens),
      .a_ones    (new_r.ones),
      .b_sign    (prev_r.sign),
      .b_huns    (prev_r.huns),
      .b_tens    (prev_r.tens),
      .b_ones    (prev_r.ones),
      .diff_sign (diff_bcd.sign),
      .diff_huns (diff_bcd.huns),
      .diff_tens (diff_bcd.tens),
      .diff_ones (diff_bcd.ones)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_WAIT_TICK;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      tick_hit    = 1'b0;
      ack_take    = 1'b0;
      timeout_hit = 1'b0;
      bad_digit   = 1'b0;
      case (state)
         ST_WAIT_TICK: begin
            if (run && tick_cnt == TICK_LAST) begin
               tick_hit   = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sample_ack) begin
               ack_take   = 1'b1;
               state_next = ST_CAPTURE;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = ST_WAIT_TICK;
            end
         end
         ST_CAPTURE: begin
            bad_digit  = bcd_has_bad_digit(new_r);
            state_next = bad_digit ? ST_WAIT_TICK : ST_DELTA;
         end
         ST_DELTA:   state_next = ST_PUBLISH;
         ST_PUBLISH: state_next = ST_WAIT_TICK;
         default:    state_next = ST_WAIT_TICK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt     <= '0;
         wait_cnt     <= '0;
         hold_cnt     <= '0;
         sample_req   <= 1'b0;
         new_r        <= '0;
         prev_r       <= '0;
         delta_r      <= '0;
         value_o      <= '0;
         delta_o      <= '0;
         have_prev    <= 1'b0;
         mon_en       <= 1'b0;
         timeout_err  <= 1'b0;
         bad_data_err <= 1'b0;
      end else begin
         if (state == ST_WAIT_TICK && run && !tick_hit) tick_cnt <= tick_cnt + TW'(1);
         else                                            tick_cnt <= '0;

         if (state == ST_REQ) wait_cnt <= wait_cnt + WW'(1);
         else                 wait_cnt <= '0;

         if (tick_hit)                       sample_req <= 1'b1;
         else if (ack_take || timeout_hit)   sample_req <= 1'b0;

         if (ack_take) new_r <= '{sign: sensor_sign, huns: sensor_huns,
                                  tens: sensor_tens, ones: sensor_ones};

         if (state == ST_DELTA) delta_r <= have_prev ? diff_bcd : '0;

         // a new tick always restarts mon_en so each publish gives a fresh rising edge
         if (state == ST_PUBLISH) begin
            value_o   <= new_r;
            delta_o   <= delta_r;
            prev_r    <= new_r;
            have_prev <= 1'b1;
            mon_en    <= 1'b1;
            hold_cnt  <= HOLD_INIT;
         end else if (tick_hit) begin
            mon_en   <= 1'b0;
            hold_cnt <= '0;
         end else if (mon_en) begin
            if (hold_cnt == '0) mon_en   <= 1'b0;
            else                hold_cnt <= hold_cnt - HW'(1);
         end

         if (clear_err) begin
            timeout_err  <= 1'b0;
            bad_data_err <= 1'b0;
         end
         if (timeout_hit) timeout_err  <= 1'b1;
         if (bad_digit)   bad_data_err <= 1'b1;
      end
   end

   assign busy            = (state != ST_WAIT_TICK);
   assign temp_value_ones = value_o.ones;
   assign temp_value_tens = value_o.tens;
   assign temp_value_huns = value_o.huns;
   assign temp_value_sign = value_o.sign;
   assign temp_delta_ones = delta_o.ones;
   assign temp_delta_tens = delta_o.tens;
   assign temp_delta_huns = delta_o.huns;
   assign temp_delta_sign = delta_o.sign;

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Directed bench for temp_sample_ctrl with TICK_DIV=8, ACK_TIMEOUT=5, EN_HOLD=3.
module tb_temp_sample_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       clear_err = 1'b0;
   logic       sample_ack = 1'b0;
   logic [3:0] sensor_ones = '0;
   logic [3:0] sensor_tens = '0;
   logic [3:0] sensor_huns = '0;
   logic       sensor_sign = 1'b0;
   logic       sample_req;
   logic [3:0] temp_value_ones, temp_value_tens, temp_value_huns;
   logic       temp_value_sign;
   logic [3:0] temp_delta_ones, temp_delta_tens, temp_delta_huns;
   logic       temp_delta_sign;
   logic       mon_en, busy, timeout_err, bad_data_err;

   logic [12:0] value_o, delta_o;
   logic [4:0]  flags_o;
   assign value_o = {temp_value_sign, temp_value_huns, temp_value_tens, temp_value_ones};
   assign delta_o = {temp_delta_sign, temp_delta_huns, temp_delta_tens, temp_delta_ones};
   assign flags_o = {sample_req, mon_en, busy, timeout_err, bad_data_err};

   temp_sample_ctrl #(.TICK_DIV(8), .ACK_TIMEOUT(5), .EN_HOLD(3)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .run             (run),
      .clear_err       (clear_err),
      .sample_ack      (sample_ack),
      .sensor_ones     (sensor_ones),
      .sensor_tens     (sensor_tens),
      .sensor_huns     (sensor_huns),
      .sensor_sign     (sensor_sign),
      .sample_req      (sample_req),
      .temp_value_ones (temp_value_ones),
      .temp_value_tens (temp_value_tens),
      .temp_value_huns (temp_value_huns),
      .temp_value_sign (temp_value_sign),
      .temp_delta_ones (temp_delta_ones),
      .temp_delta_tens (temp_delta_tens),
      .temp_delta_huns (temp_delta_huns),
      .temp_delta_sign (temp_delta_sign),
      .mon_en          (mon_en),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .bad_data_err    (bad_data_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // {sign, huns, tens, ones}; expected deltas hand-computed against the preceding reading
   logic [12:0] tv_in [0:7] = '{13'h0031, 13'h1004, 13'h1999, 13'h0999,
                                13'h0047, 13'h0047, 13'h0000, 13'h1000};
   logic [12:0] tv_dl [0:7] = '{13'h0008, 13'h1035, 13'h1995, 13'h0999,
                                13'h1952, 13'h0000, 13'h1047, 13'h0000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sample_req !== 1'b1 && n < 60);
      chk("req_seen", 32'(sample_req), 32'd1);
   endtask

   task automatic ack_sample(input logic s, input logic [3:0] h, input logic [3:0] t,
                             input logic [3:0] o, input int pre);
      wait_req();
      repeat (pre) @(negedge clk);
      sample_ack  = 1'b1;
      sensor_sign = s;
      sensor_huns = h;
      sensor_tens = t;
      sensor_ones = o;
      @(posedge clk);
      #1;
      sample_ack = 1'b0;
   endtask

   initial begin
      int cnt;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_value", value_o, 13'h0000);
      chk("rst_delta", delta_o, 13'h0000);
      chk("rst_flags", flags_o, 5'b00000);
      rst_n = 1'b1;
      run   = 1'b1;

      // first reading: no prev, delta forced to zero; 3-cycle latency, 3-cycle mon_en
      ack_sample(1'b0, 4'd0, 4'd2, 4'd3, 2);
      chk("t1_req_drop", 32'(sample_req), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("t1_early_mon", 32'(mon_en), 32'd0);
      chk("t1_early_val", value_o, 13'h0000);
      chk("t1_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk("t1_value", value_o, 13'h0023);
      chk("t1_delta", delta_o, 13'h0000);
      chk("t1_mon_rise", 32'(mon_en), 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("t1_mon_hold", 32'(mon_en), 32'd1);
      end
      @(posedge clk);
      #1;
      chk("t1_mon_fall", 32'(mon_en), 32'd0);

      for (int i = 0; i < 8; i++) begin
         ack_sample(tv_in[i][12], tv_in[i][11:8], tv_in[i][7:4], tv_in[i][3:0], 1);
         repeat (3) @(posedge clk);
         #1;
         chk("tv_value", value_o, tv_in[i]);
         chk("tv_delta", delta_o, tv_dl[i]);
         chk("tv_mon", 32'(mon_en), 32'd1);
      end

      // timeout: request held exactly ACK_TIMEOUT cycles, outputs hold
      wait_req();
      cnt = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sample_req) cnt++;
         else break;
      end
      chk("t4_req_len", cnt, 5);
      chk("t4_timeout", 32'(timeout_err), 32'd1);
      chk("t4_hold_val", value_o, 13'h1000);
      chk("t4_idle", 32'(busy), 32'd0);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("t4_cleared", 32'(timeout_err), 32'd0);
      wait_req();
      repeat (4) @(negedge clk);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      chk("t4_err_wins", 32'(timeout_err), 32'd1);
      chk("t4_req_off", 32'(sample_req), 32'd0);

      // bad digit: discarded, no mon_en, prev (-000) kept for the next delta
      ack_sample(1'b0, 4'd0, 4'hA, 4'd5, 1);
      @(posedge clk);
      #1;
      chk("t5_bad_err", 32'(bad_data_err), 32'd1);
      cnt = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (mon_en) cnt++;
      end
      chk("t5_no_mon", cnt, 0);
      chk("t5_hold_val", value_o, 13'h1000);
      ack_sample(1'b0, 4'd0, 4'd5, 4'd0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_value", value_o, 13'h0050);
      chk("t5_delta", delta_o, 13'h0050);

      // reset in REQ, then run dropped during DELTA
      wait_req();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_rst_flags", flags_o, 5'b00000);
      chk("t6_rst_value", value_o, 13'h0000);
      chk("t6_rst_delta", delta_o, 13'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      ack_sample(1'b0, 4'd1, 4'd0, 4'd0, 0);
      @(posedge clk);
      #1;
      run = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("t6_value", value_o, 13'h0100);
      chk("t6_delta", delta_o, 13'h0000);
      chk("t6_mon", 32'(mon_en), 32'd1);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (sample_req) cnt++;
      end
      chk("t6_no_req", cnt, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
